// File: rtl/dot_mac_seq.sv
// rtl/dot_mac_seq.sv - sequential dot-product MAC driving an external pipelined 16x16 multiplier
module dot_mac_seq #(
    parameter int LAT  = 4,
    parameter int ACCW = 40
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [7:0]      len,
    input  logic            in_valid,
    input  logic [15:0]     in_a,
    input  logic [15:0]     in_b,
    output logic            in_ready,
    output logic [15:0]     mul_a,
    output logic [15:0]     mul_b,
    input  logic [31:0]     mul_p,
    output logic [ACCW-1:0] acc,
    output logic            busy,
    output logic            done,
    output logic            ovf
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]    state;
    logic [7:0]    cnt;
    logic [LAT:0]  tag;
    logic          xfer;
    logic          start_ok;
    logic          last_acc;
    logic [ACCW:0] sum;

    assign in_ready = (state == S_ISSUE);
    assign busy     = (state == S_ISSUE) || (state == S_DRAIN);
    assign done     = (state == S_DONE);
    assign xfer     = in_valid && in_ready;
    assign start_ok = (state == S_IDLE) && start;

    // The extra top bit of sum is the carry out of the accumulator.
    assign sum = {1'b0, acc} + {{(ACCW + 1 - 32){1'b0}}, mul_p};

    // Once issue has finished, the slot leaving the tag line with nothing
    // behind it is the last product of the job.
    assign last_acc = tag[LAT] && (tag[LAT-1:0] == '0);

    // Operand registers and the valid-tag line that tracks products through the multiplier.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mul_a <= '0;
            mul_b <= '0;
            tag   <= '0;
        end else begin
            tag <= {tag[LAT-1:0], xfer};
            if (xfer) begin
                mul_a <= in_a;
                mul_b <= in_b;
            end
        end
    end

    // Accumulator with sticky carry-out; cleared only by an accepted start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
            ovf <= 1'b0;
        end else if (start_ok) begin
            acc <= '0;
            ovf <= 1'b0;
        end else if (tag[LAT]) begin
            acc <= sum[ACCW-1:0];
            if (sum[ACCW]) begin
                ovf <= 1'b1;
            end
        end
    end

    // Job sequencing: issue len pairs, wait for the last product, pulse done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (len != 8'd0) begin
                            cnt   <= len;
                            state <= S_ISSUE;
                        end else begin
                            state <= S_DONE;
                        end
                    end
                end
                S_ISSUE: begin
                    if (xfer) begin
                        cnt <= cnt - 8'd1;
                        if (cnt == 8'd1) begin
                            state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (last_acc) begin
                        state <= S_DONE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dot_mac_seq.sv
// tb/tb_dot_mac_seq.sv - randomized self-checking bench for dot_mac_seq (40-bit and 33-bit accumulators)
module tb_dot_mac_seq;

    localparam int LAT = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  len = 8'd0;
    logic        in_valid = 1'b0;
    logic [15:0] in_a = 16'd0;
    logic [15:0] in_b = 16'd0;

    logic        in_ready, busy, done, ovf;
    logic [15:0] mul_a, mul_b;
    logic [31:0] mul_p;
    logic [39:0] acc;

    logic        in_ready2, busy2, done2, ovf2;
    logic [15:0] mul_a2, mul_b2;
    logic [31:0] mul_p2;
    logic [32:0] acc2;

    logic [31:0] pipe  [LAT];
    logic [31:0] pipe2 [LAT];

    int vectors = 0;
    int miscompares = 0;

    int unsigned pa [256];
    int unsigned pb [256];

    always #5 clk = ~clk;

    dot_mac_seq #(.LAT(LAT), .ACCW(40)) u_dut (
        .clk(clk), .rst(rst), .start(start), .len(len),
        .in_valid(in_valid), .in_a(in_a), .in_b(in_b), .in_ready(in_ready),
        .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p),
        .acc(acc), .busy(busy), .done(done), .ovf(ovf)
    );

    dot_mac_seq #(.LAT(LAT), .ACCW(33)) u_dut33 (
        .clk(clk), .rst(rst), .start(start), .len(len),
        .in_valid(in_valid), .in_a(in_a), .in_b(in_b), .in_ready(in_ready2),
        .mul_a(mul_a2), .mul_b(mul_b2), .mul_p(mul_p2),
        .acc(acc2), .busy(busy2), .done(done2), .ovf(ovf2)
    );

    // Behavioural multipliers: LAT register stages from operands to product.
    always @(posedge clk) begin
        pipe[0]  <= 32'(mul_a) * 32'(mul_b);
        pipe2[0] <= 32'(mul_a2) * 32'(mul_b2);
        for (int i = 1; i < LAT; i++) begin
            pipe[i]  <= pipe[i-1];
            pipe2[i] <= pipe2[i-1];
        end
    end
    assign mul_p  = pipe[LAT-1];
    assign mul_p2 = pipe2[LAT-1];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_ctl(input string tag, input bit er, input bit eb, input bit ed);
        check({tag, " in_ready"}, 64'(in_ready), 64'(er));
        check({tag, " busy"}, 64'(busy), 64'(eb));
        check({tag, " done"}, 64'(done), 64'(ed));
        check({tag, " in_ready33"}, 64'(in_ready2), 64'(er));
        check({tag, " busy33"}, 64'(busy2), 64'(eb));
        check({tag, " done33"}, 64'(done2), 64'(ed));
    endtask

    task automatic check_sum(input string tag, input longint unsigned s);
        longint unsigned m40 = (64'd1 << 40) - 64'd1;
        longint unsigned m33 = (64'd1 << 33) - 64'd1;
        check({tag, " acc40"}, 64'(acc), s & m40);
        check({tag, " ovf40"}, 64'(ovf), 64'((s >> 40) != 0));
        check({tag, " acc33"}, 64'(acc2), s & m33);
        check({tag, " ovf33"}, 64'(ovf2), 64'((s >> 33) != 0));
    endtask

    // gap >= 0: fixed idle cycles between pairs; gap < 0: random gaps.
    // poke: pulse start with a different len in the middle of the job.
    task automatic run_job(input int n, input int gap, input bit poke);
        longint unsigned s = 0;
        int issued = 0;
        int wait_left = 0;
        int t_last = -1;
        int done_k;
        int k = 1;
        bit er, eb;
        for (int i = 0; i < n; i++) s += longint'(pa[i]) * longint'(pb[i]);
        done_k = (n == 0) ? 1 : -100;

        @(posedge clk); #1;
        start = 1'b1; len = 8'(n); in_valid = 1'b0;
        @(negedge clk);
        check_ctl("cyc0", 1'b0, 1'b0, 1'b0);

        while (k < 3000) begin
            @(posedge clk); #1;
            start = poke && (n > 0) && (k == 2);
            len   = start ? 8'd200 : 8'(n);
            er = (n > 0) && (issued < n);
            if (er && wait_left == 0) begin
                in_valid = 1'b1;
                in_a = 16'(pa[issued]);
                in_b = 16'(pb[issued]);
            end else begin
                in_valid = !er;
                in_a = 16'($urandom);
                in_b = 16'($urandom);
                if (er) wait_left--;
            end
            @(negedge clk);
            eb = (n > 0) && (er || k <= t_last + LAT + 1);
            check_ctl($sformatf("cyc%0d", k), er, eb, k == done_k);
            if (er && in_valid) begin
                issued++;
                wait_left = (gap >= 0) ? gap : $urandom_range(0, 3);
                if (issued == n) begin
                    t_last = k;
                    done_k = k + LAT + 2;
                end
            end
            if (k == done_k) check_sum("done", s);
            if (k == done_k + 1) break;
            k++;
        end
        check("job terminated", 64'(k < 3000), 64'd1);
        start = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check_sum("hold", s);
    endtask

    initial begin
        // Reset state
        @(posedge clk); @(posedge clk); #1;
        check_ctl("reset", 1'b0, 1'b0, 1'b0);
        check("reset acc", 64'(acc), 64'd0);
        check("reset ovf", 64'(ovf), 64'd0);
        check("reset mul_a", 64'(mul_a), 64'd0);
        check("reset mul_b", 64'(mul_b), 64'd0);
        rst = 1'b0;

        // Single pair, gapless: done 7 cycles after start
        pa[0] = 3; pb[0] = 5;
        run_job(1, 0, 0);

        // Four max pairs back to back
        for (int i = 0; i < 4; i++) begin pa[i] = 16'hFFFF; pb[i] = 16'hFFFF; end
        run_job(4, 0, 0);

        // Two-cycle gaps between pairs
        pa[0] = 1; pb[0] = 2; pa[1] = 3; pb[1] = 4; pa[2] = 5; pb[2] = 6;
        run_job(3, 2, 0);

        // Empty job
        run_job(0, 0, 0);

        // Overflow on the 33-bit instance, then cleared by the next job
        for (int i = 0; i < 3; i++) begin pa[i] = 16'hFFFF; pb[i] = 16'hFFFF; end
        run_job(3, 0, 0);
        pa[0] = 2; pb[0] = 2;
        run_job(1, 0, 0);

        // Start pulsed while busy is ignored
        for (int i = 0; i < 5; i++) begin pa[i] = $urandom_range(0, 65535); pb[i] = $urandom_range(0, 65535); end
        run_job(5, 0, 1);

        // Reset during drain with products in flight
        @(posedge clk); #1;
        start = 1'b1; len = 8'd3;
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk); #1;
            start = 1'b0;
            in_valid = (k <= 3);
            in_a = 16'hFFFF; in_b = 16'hFFFF;
        end
        check("pre-reset busy", 64'(busy), 64'd1);
        check("pre-reset in_ready", 64'(in_ready), 64'd0);
        #2 rst = 1'b1;
        #1;
        check_ctl("async reset", 1'b0, 1'b0, 1'b0);
        check("async reset acc", 64'(acc), 64'd0);
        check("async reset ovf33", 64'(ovf2), 64'd0);
        check("async reset mul_a", 64'(mul_a), 64'd0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        in_valid = 1'b0;
        pa[0] = 7; pb[0] = 7;
        run_job(1, 0, 0);

        // Randomized jobs with random gaps and operands
        for (int j = 0; j < 12; j++) begin
            int n = $urandom_range(1, 12);
            for (int i = 0; i < n; i++) begin
                pa[i] = ($urandom_range(0, 3) == 0) ? 16'hFFFF : $urandom_range(0, 65535);
                pb[i] = ($urandom_range(0, 3) == 0) ? 16'hFFFF : $urandom_range(0, 65535);
            end
            run_job(n, ($urandom_range(0, 1) == 0) ? 0 : -1, $urandom_range(0, 1) == 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/dot_mac_seq.md
DOT_MAC_SEQ -- requirements
Module: dot_mac_seq

Interface
REQ-001 The block SHALL have parameter LAT, default 4: register stages in the downstream 16x16 Wallace multiplier between mul_a/mul_b and mul_p.
REQ-002 The block SHALL have parameter ACCW, default 40: accumulator width, always 33 or more.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port start, input, 1 bit: begin a dot-product job; sampled only in IDLE.
REQ-006 The block SHALL have port len, input, 8 bits: number of operand pairs in the job, 0 to 255, sampled with start.
REQ-007 The block SHALL have ports in_valid (input, 1 bit), in_a (input, 16 bits) and in_b (input, 16 bits): the operand stream, unsigned.
REQ-008 The block SHALL have port in_ready, output, 1 bit: the block accepts a pair this cycle.
REQ-009 The block SHALL have ports mul_a and mul_b, outputs, 16 bits each: registered operands driving the multiplier.
REQ-010 The block SHALL have port mul_p, input, 32 bits: multiplier product.
REQ-011 The block SHALL have port acc, output, ACCW bits: running and final sum.
REQ-012 The block SHALL have ports busy, done and ovf, outputs, 1 bit each: job active; one-cycle completion pulse; sticky accumulator carry-out.

Function
REQ-013 The FSM SHALL have states IDLE, ISSUE, DRAIN and DONE.
REQ-014 In IDLE with start=1 and len!=0, the block SHALL clear acc and ovf, load the issue counter with len, and go to ISSUE.
REQ-015 In IDLE with start=1 and len==0, the block SHALL clear acc and ovf and go to DONE.
REQ-016 The block SHALL ignore start outside IDLE.
REQ-017 in_ready SHALL be 1 only in ISSUE.
REQ-018 A transfer SHALL occur on the edge where in_valid and in_ready are both 1.
REQ-019 On a transfer, the block SHALL load mul_a/mul_b with in_a/in_b, decrement the issue counter, and insert a valid tag into a LAT+1 deep tag shift register.
REQ-020 Without a transfer, mul_a/mul_b SHALL hold their value and a zero tag SHALL be inserted.
REQ-021 Gaps in in_valid SHALL only delay issue; they SHALL NOT corrupt the sum.
REQ-022 On the transfer that brings the issue counter to 0, the block SHALL go from ISSUE to DRAIN.
REQ-023 For operands first present on mul_a/mul_b in cycle c, mul_p SHALL be added to acc at the edge ending cycle c+LAT; acc = (acc + zero-extended mul_p) mod 2^ACCW.
REQ-024 Accumulation SHALL occur only for tagged slots; untagged mul_p values SHALL be ignored.
REQ-025 On any accumulation with carry out of bit ACCW-1, ovf SHALL set to 1 and stay 1 until the next accepted start or rst.
REQ-026 The block SHALL go from DRAIN to DONE at the edge performing the final accumulation of the job.
REQ-027 In DONE, done SHALL be 1 for exactly one cycle, then the block SHALL return to IDLE.
REQ-028 busy SHALL be 1 in ISSUE and DRAIN and 0 in IDLE and DONE.
REQ-029 acc and ovf SHALL hold their final values in DONE and IDLE until the next accepted start.
REQ-030 With LAT=4 and in_valid held at 1, done SHALL be high in cycle start_cycle+LAT+len+2, so len=1 gives cycle +7.

Reset
REQ-031 While rst=1, irrespective of clk, the block SHALL force: state=IDLE, acc=0, ovf=0, done=0, busy=0, in_ready=0, mul_a=0, mul_b=0, all tags=0, issue counter=0.
REQ-032 A rst asserted mid-job SHALL abandon the job; no stale tagged product SHALL be accumulated after rst deasserts.
REQ-033 The first start after rst deasserts SHALL be accepted normally.

Verification
REQ-034 len=1, in_a=3, in_b=5, in_valid held 1, LAT=4 -> done pulse 7 cycles after start, acc=15, ovf=0, busy high cycles 1..6.
REQ-035 len=4, all pairs 0xFFFF x 0xFFFF back-to-back -> acc=0x3FFF80004, ovf=0, exactly one done pulse.
REQ-036 len=3, pairs (1,2),(3,4),(5,6) with in_valid low for 2 cycles between each pair -> acc=44, in_ready high throughout ISSUE, done delayed by exactly 4 cycles versus the gapless case.
REQ-037 len=0 with start -> done=1 in the next cycle, acc=0, in_ready never 1.
REQ-038 ACCW=33, len=3, 0xFFFF x 0xFFFF -> acc=0x0FFFA0003, ovf=1; a later job with len=1, (2,2) -> acc=4, ovf=0.
REQ-039 rst pulsed during DRAIN with products in flight, then a new job len=1, (7,7) -> acc=49 only; start pulsed during busy -> ignored, len unchanged.
